// File: rtl/model_stream_adapter.sv
// Streaming adapter around the parallel-port inference core: packs input beats
// into x, fires the core, captures y and drains it as output beats.
module model_stream_adapter #(
  parameter int XD        = 64,
  parameter int XB        = 11,
  parameter int YD        = 16,
  parameter int YB        = 10,
  parameter int IN_LANES  = 8,
  parameter int OUT_LANES = 4,
  parameter int LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_LANES*XB-1:0]  s_data,
  input  logic                    s_last,
  output logic [XD*XB-1:0]        x,
  output logic                    en,
  input  logic [YD*YB-1:0]        y,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUT_LANES*YB-1:0] m_data,
  output logic                    m_last,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int NIB = XD / IN_LANES;
  localparam int NOB = YD / OUT_LANES;
  localparam int BW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int OW  = (NOB > 1) ? $clog2(NOB) : 1;
  localparam int WW  = $clog2(LATENCY + 1);
  localparam logic [BW-1:0] B_LAST = BW'(NIB - 1);
  localparam logic [OW-1:0] O_LAST = OW'(NOB - 1);
  localparam logic [WW-1:0] W_INIT = WW'(LATENCY);
  localparam logic [WW-1:0] W_ONE  = WW'(1);

  if (XD % IN_LANES != 0) begin : g_chk_in
    $error("XD must be a multiple of IN_LANES");
  end
  if (YD % OUT_LANES != 0) begin : g_chk_out
    $error("YD must be a multiple of OUT_LANES");
  end
  if (LATENCY < 1) begin : g_chk_lat
    $error("LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT, S_HOLD} state_t;

  state_t              state, state_nx;
  logic [BW-1:0]       bcnt;
  logic [OW-1:0]       obeat;
  logic [WW-1:0]       wcnt;
  logic [YD*YB-1:0]    y_buf;
  logic                beat_ok;
  logic                in_final;
  logic                wait_done;
  logic                capture;

  always_comb begin
    beat_ok   = s_valid && (state == S_LOAD);
    in_final  = (bcnt == B_LAST);
    wait_done = (state == S_WAIT) && (wcnt == W_ONE);
    // The out side must already be idle at the start of the cycle to capture.
    capture   = (wait_done || (state == S_HOLD)) && !m_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD: if (beat_ok && in_final && s_last) state_nx = S_FIRE;
      S_FIRE: state_nx = S_WAIT;
      S_WAIT: if (wait_done) state_nx = capture ? S_LOAD : S_HOLD;
      S_HOLD: if (capture) state_nx = S_LOAD;
      default: state_nx = S_LOAD;
    endcase
  end

  always_comb begin
    s_ready = (state == S_LOAD);
    en      = (state == S_FIRE);
    busy    = (state != S_LOAD) || m_valid;
    m_last  = m_valid && (obeat == O_LAST);
    m_data  = '0;
    for (int unsigned k = 0; k < NOB; k++) begin
      if (obeat == OW'(k)) m_data = y_buf[k*OUT_LANES*YB +: OUT_LANES*YB];
    end
  end

  // A misplaced s_last, or a full frame without one, drops the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcnt      <= '0;
      x         <= '0;
      frame_err <= 1'b0;
    end else if (beat_ok) begin
      for (int unsigned b = 0; b < NIB; b++) begin
        if (bcnt == BW'(b)) x[b*IN_LANES*XB +: IN_LANES*XB] <= s_data;
      end
      if (s_last || in_final) bcnt <= '0;
      else                    bcnt <= bcnt + 1'b1;
      if (s_last != in_final) frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt <= '0;
    end else if (state == S_FIRE) begin
      wcnt <= W_INIT;
    end else if ((state == S_WAIT) && (wcnt != '0)) begin
      wcnt <= wcnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_buf   <= '0;
      m_valid <= 1'b0;
      obeat   <= '0;
    end else if (capture) begin
      y_buf   <= y;
      m_valid <= 1'b1;
      obeat   <= '0;
    end else if (m_valid && m_ready) begin
      if (obeat == O_LAST) begin
        m_valid <= 1'b0;
        obeat   <= '0;
      end else begin
        obeat <= obeat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_model_stream_adapter.sv
// Randomized bench for model_stream_adapter: LATENCY=1 and LATENCY=3 instances,
// each with a core stub, checked against a frame-level reference queue.
module tb_model_stream_adapter;

  localparam int XD = 64, XB = 11, YD = 16, YB = 10;
  localparam int IN_LANES = 8, OUT_LANES = 4;
  localparam int NIB = XD / IN_LANES;
  localparam int NOB = YD / OUT_LANES;
  localparam int LAT0 = 1, LAT1 = 3;
  localparam int QW = OUT_LANES*YB + 1;

  logic clk;
  logic rstn [2];
  logic s_valid [2], s_ready [2], s_last [2], en [2];
  logic m_valid [2], m_ready [2], m_last [2], frame_err [2], busy [2];
  logic [IN_LANES*XB-1:0]  s_data [2];
  logic [XD*XB-1:0]        x_o [2];
  logic [OUT_LANES*YB-1:0] m_data [2];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_mode [2];
  int en_cnt [2], nfr [2], en_cyc [2];
  bit err_exp [2], pend_exact [2];
  logic [QW-1:0] q0 [$];
  logic [QW-1:0] q1 [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? LAT0 : LAT1;
    logic [YD*YB-1:0] y_core, y_calc;
    logic [3:0] sh;
    logic [4:0] chain;

    model_stream_adapter #(
      .XD(XD), .XB(XB), .YD(YD), .YB(YB),
      .IN_LANES(IN_LANES), .OUT_LANES(OUT_LANES), .LATENCY(LAT)
    ) dut (
      .clk(clk), .rstn(rstn[g]),
      .s_valid(s_valid[g]), .s_ready(s_ready[g]), .s_data(s_data[g]), .s_last(s_last[g]),
      .x(x_o[g]), .en(en[g]), .y(y_core),
      .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_data(m_data[g]), .m_last(m_last[g]),
      .frame_err(frame_err[g]), .busy(busy[g])
    );

    // Core stub: y[i] = x[i][YB-1:0] + i, valid LAT cycles after en; junk before that.
    always_comb begin
      y_calc = '0;
      for (int i = 0; i < YD; i++) y_calc[i*YB +: YB] = x_o[g][i*XB +: YB] + YB'(i);
    end
    assign chain = {sh, en[g]};
    always @(posedge clk) begin
      sh <= chain[3:0];
      if (chain[LAT-1]) y_core <= y_calc;
      else if (en[g])   y_core <= '1;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input int d, input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h expected %0h", d, tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic q_push(input int d, input logic [QW-1:0] v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic q_pop(input int d, output logic [QW-1:0] v);
    if (d == 0) v = q0.pop_front();
    else        v = q1.pop_front();
  endtask

  task automatic q_clear(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  // Output monitor: ordering, hold-under-stall, en width and capture latency.
  initial begin
    bit                      prev_stall [2];
    bit                      prev_en [2];
    bit                      prev_v [2];
    logic                    prev_last [2];
    logic [OUT_LANES*YB-1:0] prev_data [2];
    logic [QW-1:0]           ev;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rstn[d]) begin
          prev_stall[d] = 0; prev_en[d] = 0; prev_v[d] = 0; pend_exact[d] = 0;
        end else begin
          if (prev_stall[d]) begin
            check(d, "stall_valid", m_valid[d], 1);
            check(d, "stall_data", m_data[d], prev_data[d]);
            check(d, "stall_last", m_last[d], prev_last[d]);
          end
          if (m_valid[d] && !prev_v[d] && pend_exact[d]) begin
            check(d, "capture_latency", cyc - en_cyc[d], lat_of(d) + 1);
            pend_exact[d] = 0;
          end
          if (en[d]) begin
            check(d, "en_single_cycle", prev_en[d], 0);
            en_cnt[d]++;
            en_cyc[d] = cyc;
            pend_exact[d] = !m_valid[d];
          end
          if (m_valid[d] && m_ready[d]) begin
            if (q_size(d) == 0) begin
              check(d, "unexpected_beat", m_valid[d], 0);
            end else begin
              q_pop(d, ev);
              check(d, "m_data", m_data[d], ev[QW-2:0]);
              check(d, "m_last", m_last[d], ev[QW-1]);
            end
          end
          prev_stall[d] = m_valid[d] && !m_ready[d];
          prev_en[d]    = en[d];
          prev_v[d]     = m_valid[d];
          prev_data[d]  = m_data[d];
          prev_last[d]  = m_last[d];
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      case (rdy_mode[d])
        0:       m_ready[d] = 1'b1;
        1:       m_ready[d] = ($urandom_range(0, 3) != 0);
        default: m_ready[d] = 1'b0;
      endcase
    end
  end

  // kind 0: element i = base+i; otherwise random. Returns at posedge+1.
  task automatic send_frame(input int d, input int nb, input int last_at, input int kind,
                            input int base, input bit gaps);
    logic [XB-1:0]          elem [XD];
    logic [IN_LANES*XB-1:0] sd;
    logic [QW-1:0]          ev;
    int  idx, wait_n;
    bit  acc, ok;
    for (int i = 0; i < XD; i++) elem[i] = (kind == 0) ? XB'(base + i) : XB'($urandom);
    ok = 1;
    for (int b = 0; b < nb; b++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          s_valid[d] = 1'b0;
          @(posedge clk); #1;
        end
      end
      for (int j = 0; j < IN_LANES; j++) sd[j*XB +: XB] = elem[b*IN_LANES + j];
      s_valid[d] = 1'b1;
      s_data[d]  = sd;
      s_last[d]  = (b == last_at);
      wait_n = 0;
      do begin
        @(negedge clk);
        acc = s_ready[d];
        wait_n++;
        @(posedge clk); #1;
      end while (!acc && wait_n < 500);
      if (!acc) begin
        check(d, "s_ready_timeout", acc, 1);
        ok = 0;
        break;
      end
    end
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
    if (ok) begin
      if (nb == NIB && last_at == NIB - 1) begin
        nfr[d]++;
        for (int k = 0; k < NOB; k++) begin
          ev = '0;
          for (int j = 0; j < OUT_LANES; j++) begin
            idx = k*OUT_LANES + j;
            ev[j*YB +: YB] = YB'(elem[idx]) + YB'(idx);
          end
          ev[QW-1] = (k == NOB - 1);
          q_push(d, ev);
        end
      end else begin
        err_exp[d] = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    bit done = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      done = !busy[d] && !m_valid[d] && (q_size(d) == 0);
    end
    check(d, "idle_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input int d);
    check(d, "rst_s_ready", s_ready[d], 1);
    check(d, "rst_en", en[d], 0);
    check(d, "rst_m_valid", m_valid[d], 0);
    check(d, "rst_m_last", m_last[d], 0);
    check(d, "rst_m_data", m_data[d], 0);
    check(d, "rst_frame_err", frame_err[d], 0);
    check(d, "rst_busy", busy[d], 0);
    check(d, "rst_x_zero", (x_o[d] == '0), 1);
  endtask

  task automatic run_seq(input int d);
    int k, nb;
    // Ramp frame, no backpressure: en right after the last beat, y[i] = 2i.
    rdy_mode[d] = 0;
    send_frame(d, NIB, NIB - 1, 0, 0, 0);
    check(d, "en_after_last_beat", en[d], 1);
    wait_idle(d);
    check(d, "frame_err_clean", frame_err[d], 0);

    // Random frames with input gaps and random output stalls.
    rdy_mode[d] = 1;
    repeat (4) send_frame(d, NIB, NIB - 1, 1, 0, 1);
    wait_idle(d);

    // Second frame loads while the first is stalled; it must wait in HOLD.
    rdy_mode[d] = 2;
    send_frame(d, NIB, NIB - 1, 0, 0, 0);
    send_frame(d, NIB, NIB - 1, 0, 100, 0);
    repeat (10) @(posedge clk);
    #1;
    check(d, "hold_s_ready", s_ready[d], 0);
    check(d, "hold_busy", busy[d], 1);
    check(d, "hold_m_valid", m_valid[d], 1);
    rdy_mode[d] = 0;
    wait_idle(d);

    // Early s_last, then a full frame without s_last: both dropped.
    send_frame(d, 4, 3, 1, 0, 0);
    @(negedge clk);
    check(d, "early_last_err", frame_err[d], err_exp[d]);
    check(d, "early_last_s_ready", s_ready[d], 1);
    @(posedge clk); #1;
    send_frame(d, NIB, -1, 1, 0, 0);
    send_frame(d, NIB, NIB - 1, 0, 7, 0);
    wait_idle(d);
    check(d, "err_sticky", frame_err[d], err_exp[d]);

    // Reset while waiting on the core drops the frame.
    send_frame(d, NIB, NIB - 1, 1, 0, 0);
    check(d, "en_before_reset", en[d], 1);
    @(posedge clk); #1;
    rstn[d] = 1'b0;
    #1;
    check_reset_values(d);
    q_clear(d);
    err_exp[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn[d] = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check(d, "no_valid_after_reset", m_valid[d], 0);
    end
    @(posedge clk); #1;
    send_frame(d, NIB, NIB - 1, 1, 0, 0);
    wait_idle(d);

    // Random mix of good and malformed frames under random backpressure.
    rdy_mode[d] = 1;
    repeat (10) begin
      k = $urandom_range(0, 4);
      if (k == 0) begin
        nb = $urandom_range(1, NIB - 1);
        send_frame(d, nb, nb - 1, 1, 0, 1);
      end else if (k == 1) begin
        send_frame(d, NIB, -1, 1, 0, 1);
      end else begin
        send_frame(d, NIB, NIB - 1, 1, 0, 1);
      end
    end
    wait_idle(d);

    check(d, "en_pulse_count", en_cnt[d], nfr[d]);
    check(d, "final_frame_err", frame_err[d], err_exp[d]);
    check(d, "beats_outstanding", q_size(d), 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; s_valid[d] = 1'b0; s_last[d] = 1'b0; s_data[d] = '0;
      m_ready[d] = 1'b1; rdy_mode[d] = 0;
      en_cnt[d] = 0; nfr[d] = 0; en_cyc[d] = 0; err_exp[d] = 1'b0; pend_exact[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_reset_values(d);
    for (int d = 0; d < 2; d++) rstn[d] = 1'b1;
    @(posedge clk); #1;
    fork
      run_seq(0);
      run_seq(1);
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
